sumador_multipalabra_ctrl: RTL and testbench
============================================

# sumador_multipalabra_ctrl

Sequencer that performs NWORDS×16-bit add/subtract by driving a single registered 16-bit adder slice one word per cycle, chaining the slice's registered carry into the next word. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It lets wide-operand arithmetic reuse the existing 16-bit adder instead of instantiating a wide one.

## Interface
- NWORDS, 4: number of 16-bit words per operand; ≥2; total width W = 16·NWORDS.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands and opcode present.
- in_ready  out  1  block accepts operands; high iff state IDLE.
- op_a  in  W  first operand.
- op_b  in  W  second operand.
- sub  in  1  0 = A+B, 1 = A−B (A + ~B + 1).
- out_valid  out  1  result, carry_out and zero valid.
- out_ready  in  1  consumer takes result.
- result  out  W  sum/difference, modulo 2^W.
- carry_out  out  1  carry from the top word; for subtract, 1 = no borrow.
- zero  out  1  result == 0.

## Operation
- FSM states: IDLE, RUN, CAP, DONE.
- IDLE: in_ready=1. On in_valid&in_ready: latch op_a, op_b (inverted if sub), and sub; clear word index k=0; go RUN.
- RUN: present word k of A and B to the slice; carry_in = sub for k=0, else the slice's carry_out register. From k≥1, capture the slice's SUM into result word k−1. When k=NWORDS−1, go CAP; else k++.
- CAP: capture slice SUM into result word NWORDS−1, slice carry_out into carry_out, compute zero; go DONE.
- DONE: out_valid=1; result, carry_out and zero held stable. On out_ready go IDLE.
- in_valid outside IDLE is ignored and has no side effects.
- Slice reset tied to rst. Its state from a previous operation never affects a new one, because word 0 always takes carry_in from sub.
- Arithmetic is modulo 2^W; no signed-overflow flag.

## Timing
- Reset values: in_ready=1, out_valid=0, result=0, carry_out=0, zero=0, state IDLE, k=0.
- Reset asserted mid-operation: immediate return to the reset values; the partial result is discarded.
- Latency: with acceptance at edge E0, out_valid rises at edge E(NWORDS+1); for NWORDS=4 that is 5 edges.
- Throughput: one operation per NWORDS+3 cycles minimum (DONE→IDLE costs one cycle; no accept in DONE).
- Backpressure: out_valid held with all outputs stable for as long as out_ready=0; in_ready stays 0.
- out_ready while out_valid=0 is ignored.

## Structure
- Shared package: FSM state enum (IDLE/RUN/CAP/DONE), WORD_W=16 constant.
- One sub-module: the existing 16-bit registered adder slice, sumador_sincrono_16bits, instantiated once. The controller owns word muxing, carry chaining and result assembly.

## Test plan
- NWORDS=4, sub=0: 0xFFFF_FFFF_FFFF_FFFF + 0x1 -> result 0, carry_out=1, zero=1; out_valid at 5th edge after accept.
- Add 0x0001_FFFF_0000_FFFF + 0x0000_0001_0000_0001 -> 0x0002_0000_0001_0000, carry_out=0, zero=0. Checks per-word carry chaining.
- sub=1: 0x0000_0000_0001_0000 − 0x1 -> 0x0000_0000_0000_FFFF, carry_out=1. Then 0 − 1 -> 0xFFFF_FFFF_FFFF_FFFF, carry_out=0.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid, pulsing in_valid with new operands -> outputs stable, in_ready=0, the new operands are not accepted. Release out_ready -> in_ready=1 the next cycle.
- Assert rst in RUN after 2 words -> all outputs at reset values. The next op 0x1234 + 0x4321 -> 0x5555, carry_out=0.
- Back-to-back: in_valid held high with out_ready=1 -> two operations accepted NWORDS+3 cycles apart, both results correct.

Source files
------------

// File: rtl/sumador_multipalabra_ctrl_pkg.sv
// Shared definitions for the multi-word add/subtract sequencer.
//   WORD_W  : width of the adder slice reused for each word
//   state_t : controller FSM states
package sumador_multipalabra_ctrl_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CAP,
    DONE
  } state_t;

endpackage

// File: rtl/sumador_multipalabra_ctrl_slice.sv
// Registered 16-bit adder slice: {cout, sum} <= a + b + cin on each rising edge.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   a, b, cin    : word operands and carry in
//   sum, cout    : registered sum and carry out
module sumador_sincrono_16bits (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      {cout, sum} <= {1'b0, a} + {1'b0, b} + {16'b0, cin};
    end
  end

endmodule

// File: rtl/sumador_multipalabra_ctrl.sv
// Multi-word add/subtract sequencer. Drives one registered 16-bit adder slice
// one word per cycle, chaining the slice's registered carry between words.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   in_valid/in_ready         : operand handshake (ready only in IDLE)
//   op_a, op_b, sub           : W-bit operands; sub=1 computes A-B
//   out_valid/out_ready       : result handshake (valid only in DONE)
//   result, carry_out, zero   : sum/difference mod 2^W, top carry, result==0
module sumador_multipalabra_ctrl
  import sumador_multipalabra_ctrl_pkg::*;
#(
  parameter  int unsigned NWORDS = 4,
  localparam int unsigned W      = WORD_W * NWORDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         zero
);

  localparam int unsigned    K_W    = $clog2(NWORDS);
  localparam logic [K_W-1:0] K_LAST = K_W'(NWORDS - 1);

  state_t              state_q, state_d;
  logic [K_W-1:0]      k_q;
  logic [W-1:0]        a_q, b_q, result_q, result_shift;
  logic                sub_q, carry_q, zero_q;
  logic [WORD_W-1:0]   slice_sum;
  logic                slice_cin, slice_cout;

  // Operands are shifted right one word per RUN cycle, so the slice always
  // sees the current word in the low bits; result words are shifted in from
  // the top, leaving word 0 at the bottom after NWORDS captures.
  assign result_shift = {slice_sum, result_q[W-1:WORD_W]};

  sumador_sincrono_16bits u_slice (
    .clk  (clk),
    .rst  (rst),
    .a    (a_q[WORD_W-1:0]),
    .b    (b_q[WORD_W-1:0]),
    .cin  (slice_cin),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    // Word 0 never uses the slice's stale carry, so earlier operations cannot leak in.
    slice_cin = (k_q == '0) ? sub_q : slice_cout;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (k_q == K_LAST) state_d = CAP;
      end
      CAP: begin
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      k_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= op_a;
            b_q   <= sub ? ~op_b : op_b;
            sub_q <= sub;
            k_q   <= '0;
          end
        end
        RUN: begin
          a_q <= a_q >> WORD_W;
          b_q <= b_q >> WORD_W;
          if (k_q != K_LAST) k_q <= k_q + K_W'(1);
          if (k_q != '0) result_q <= result_shift;
        end
        CAP: begin
          result_q <= result_shift;
          carry_q  <= slice_cout;
          zero_q   <= (result_shift == '0);
        end
        default: ;
      endcase
    end
  end

  assign result    = result_q;
  assign carry_out = carry_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_sumador_multipalabra_ctrl.sv
// Self-checking bench for sumador_multipalabra_ctrl (NWORDS=4, W=64).
module tb_sumador_multipalabra_ctrl;

  localparam int unsigned NW = 4;
  localparam int unsigned W  = 16 * NW;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         carry_out;
  logic         zero;

  int checks = 0;
  int errors = 0;

  sumador_multipalabra_ctrl #(.NWORDS(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  // Reference: wide arithmetic straight from the operation's definition.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic s);
    logic [W:0] r;
    if (s) begin
      r[W-1:0] = a - b;
      r[W]     = (a >= b);
    end else begin
      r = {1'b0, a} + {1'b0, b};
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    for (int unsigned i = 0; i < NW; i++) v[i*16 +: 16] = 16'($urandom);
    return v;
  endfunction

  // Stimulus: present one operation from IDLE, wait (bounded) for out_valid.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output logic [W-1:0] r, output logic c, output logic z,
                        output int lat);
    op_a = a; op_b = b; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result; c = carry_out; z = zero;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    checks++; if (carry_out !== 1'b0 || zero !== 1'b0) begin errors++; $display("FAIL reset_flags: got c=%b z=%b expected 0 0", carry_out, zero); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic         vs [4];
    logic [W-1:0] r; logic c, z; int lat; logic [W:0] e;
    va[0] = 64'hFFFF_FFFF_FFFF_FFFF; vb[0] = 64'h1;                   vs[0] = 1'b0;
    va[1] = 64'h0001_FFFF_0000_FFFF; vb[1] = 64'h0000_0001_0000_0001; vs[1] = 1'b0;
    va[2] = 64'h0000_0000_0001_0000; vb[2] = 64'h1;                   vs[2] = 1'b1;
    va[3] = 64'h0;                   vb[3] = 64'h1;                   vs[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], vs[i], r, c, z, lat);
      e = model(va[i], vb[i], vs[i]);
      checks++; if (lat != NW + 1) begin errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, NW + 1); end
      checks++; if (r !== e[W-1:0]) begin errors++; $display("FAIL dir%0d_result: got %h expected %h", i, r, e[W-1:0]); end
      checks++; if (c !== e[W]) begin errors++; $display("FAIL dir%0d_carry: got %b expected %b", i, c, e[W]); end
      checks++; if (z !== (e[W-1:0] == '0)) begin errors++; $display("FAIL dir%0d_zero: got %b expected %b", i, z, (e[W-1:0] == '0)); end
      release_out();
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, r; logic s, c, z; int lat; logic [W:0] e;
    for (int i = 0; i < 20; i++) begin
      a = rand_word(); b = rand_word(); s = 1'($urandom);
      if (i == 3) b = a;
      run_op(a, b, s, r, c, z, lat);
      e = model(a, b, s);
      checks++; if (lat != NW + 1) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, NW + 1); end
      checks++; if (r !== e[W-1:0] || c !== e[W] || z !== (e[W-1:0] == '0))
        begin errors++; $display("FAIL rnd%0d_out: got %h c=%b z=%b expected %h c=%b z=%b", i, r, c, z, e[W-1:0], e[W], (e[W-1:0] == '0)); end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b, r; logic c, z; int lat; logic [W:0] e;
    a = rand_word(); b = rand_word();
    run_op(a, b, 1'b0, r, c, z, lat);
    e = model(a, b, 1'b0);
    for (int i = 0; i < 3; i++) begin
      op_a = rand_word(); op_b = rand_word(); sub = 1'($urandom); in_valid = 1'b1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
        begin errors++; $display("FAIL bp%0d_handshake: got v=%b r=%b expected 1 0", i, out_valid, in_ready); end
      checks++; if (result !== e[W-1:0] || carry_out !== e[W] || zero !== (e[W-1:0] == '0))
        begin errors++; $display("FAIL bp%0d_hold: got %h c=%b expected %h c=%b", i, result, carry_out, e[W-1:0], e[W]); end
    end
    in_valid = 1'b0;
    release_out();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin errors++; $display("FAIL bp_release: got r=%b v=%b expected 1 0", in_ready, out_valid); end
    checks++; if (result !== e[W-1:0]) begin errors++; $display("FAIL bp_no_accept: got %h expected %h", result, e[W-1:0]); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] r; logic c, z; int lat;
    op_a = 64'hDEAD_BEEF_1234_5678; op_b = 64'h1111_2222_3333_4444; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin errors++; $display("FAIL rstmid_handshake: got r=%b v=%b expected 1 0", in_ready, out_valid); end
    checks++; if (result !== '0 || carry_out !== 1'b0 || zero !== 1'b0)
      begin errors++; $display("FAIL rstmid_outputs: got %h c=%b z=%b expected 0 0 0", result, carry_out, zero); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(64'h1234, 64'h4321, 1'b0, r, c, z, lat);
    checks++; if (r !== 64'h5555 || c !== 1'b0 || z !== 1'b0 || lat != NW + 1)
      begin errors++; $display("FAIL rstmid_next: got %h c=%b z=%b lat=%0d expected 5555 0 0 %0d", r, c, z, lat, NW + 1); end
    release_out();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a [2]; logic [W-1:0] b [2]; logic s [2];
    logic [W-1:0] got [2];
    int acc_cyc [2];
    int accepts = 0, results = 0, n = 0;
    logic acc;
    logic [W:0] e;
    for (int i = 0; i < 2; i++) begin a[i] = rand_word(); b[i] = rand_word(); s[i] = 1'($urandom); end
    op_a = a[0]; op_b = b[0]; sub = s[0]; in_valid = 1'b1; out_ready = 1'b1;
    while (results < 2 && n < 40) begin
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin got[results] = result; results++; end
      @(posedge clk); #1;
      n++;
      if (acc) begin
        acc_cyc[accepts] = n; accepts++;
        if (accepts == 1) begin op_a = a[1]; op_b = b[1]; sub = s[1]; end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (accepts != 2 || results != 2)
      begin errors++; $display("FAIL b2b_count: got acc=%0d res=%0d expected 2 2", accepts, results); end
    else begin
      checks++; if (acc_cyc[1] - acc_cyc[0] != NW + 3)
        begin errors++; $display("FAIL b2b_gap: got %0d expected %0d", acc_cyc[1] - acc_cyc[0], NW + 3); end
      for (int i = 0; i < 2; i++) begin
        e = model(a[i], b[i], s[i]);
        checks++; if (got[i] !== e[W-1:0]) begin errors++; $display("FAIL b2b_result%0d: got %h expected %h", i, got[i], e[W-1:0]); end
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
